// File: rtl/rv32_types_pkg.sv
// Shared RV32 register-file types: register ids, data words, write requests
// and the 32-entry pending-write mask used by the write-back scoreboard.
package rv32_types;

  localparam int RV_NUM_REGS = 32;

  typedef logic [4:0]             rv_reg_id_t;
  typedef logic [31:0]            rv32_word;
  typedef logic [RV_NUM_REGS-1:0] rv_reg_mask_t;

  typedef struct packed {
    logic       write;
    rv_reg_id_t id;
    rv32_word   data;
  } register_write_request_t;

endpackage

// File: rtl/rv32_rr_arbiter.sv
// Combinational round-robin picker: the first set request found when walking
// upward (with wrap) from ptr wins; grant is one-hot or zero.
module rv32_rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);

  // Walk from lowest to highest priority so the last hit (closest to ptr) wins.
  always_comb begin
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[PW'((int'(ptr) + k) % N)]) begin
        grant = '0;
        grant[PW'((int'(ptr) + k) % N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Write-back arbiter: picks one requester per cycle round-robin, registers the
// winning write toward the register file, and tracks pending destinations.
module rv32_wb_arbiter
  import rv32_types::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  register_write_request_t [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic                                  reserve_valid,
  input  rv_reg_id_t                            reserve_id,
  output register_write_request_t               write_request,
  output rv_reg_mask_t                          busy
);

  localparam int PW = $clog2(NUM_REQ);

  // Handshake: requester i is accepted in a cycle where req_valid[i] and
  // req_ready[i] are both high; it must hold valid and payload until then.
  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           next_ptr;
  logic [NUM_REQ-1:0]      grant;
  logic                    accept;
  logic                    commit_write;
  register_write_request_t sel;
  rv_reg_mask_t            busy_next;

  rv32_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = resetn ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    sel      = '0;
    next_ptr = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel      = req[i];
        next_ptr = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  assign commit_write = accept & sel.write & (sel.id != '0);

  // A same-cycle reserve wins over the release: a new producer is in flight.
  always_comb begin
    busy_next = busy;
    if (commit_write) busy_next[sel.id] = 1'b0;
    if (reserve_valid && reserve_id != '0) busy_next[reserve_id] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr        <= '0;
      busy          <= '0;
      write_request <= '0;
    end else begin
      rr_ptr <= next_ptr;
      busy   <= busy_next;
      if (accept) begin
        write_request.write <= commit_write;
        write_request.id    <= sel.id;
        write_request.data  <= sel.data;
      end else begin
        write_request.write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Bench for rv32_wb_arbiter: directed vectors with literal expectations plus a
// per-cycle comparison against a queue/array-based reference model.
module tb_rv32_wb_arbiter;
  import rv32_types::*;

  localparam int N = 3;
  localparam int W = $bits(register_write_request_t);

  logic                            clk;
  logic                            resetn;
  logic [N-1:0]                    req_valid;
  register_write_request_t [N-1:0] req;
  logic [N-1:0]                    req_ready;
  logic                            reserve_valid;
  rv_reg_id_t                      reserve_id;
  register_write_request_t         write_request;
  rv_reg_mask_t                    busy;

  rv32_wb_arbiter #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req           (req),
    .req_ready     (req_ready),
    .reserve_valid (reserve_valid),
    .reserve_id    (reserve_id),
    .write_request (write_request),
    .busy          (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic register_write_request_t mk(input logic w, input int id, input logic [31:0] d);
    register_write_request_t r;
    r.write = w;
    r.id    = rv_reg_id_t'(id);
    r.data  = d;
    return r;
  endfunction

  // Round-robin rule: first valid index at or after p, wrapping; -1 if none.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  int                      m_ptr;
  logic [31:0]             m_busy;
  register_write_request_t m_wr;
  logic [W-1:0]            exp_q[$];
  int                      m_g;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ptr  = 0;
      m_busy = '0;
      m_wr   = '0;
      exp_q.delete();
    end else begin
      m_g = rr_pick(req_valid, m_ptr);
      if (m_g >= 0) begin
        m_wr = req[m_g];
        if (m_wr.id == 0) m_wr.write = 1'b0;
        if (m_wr.write) m_busy[m_wr.id] = 1'b0;
        m_ptr = (m_g + 1) % N;
      end else begin
        m_wr.write = 1'b0;
      end
      if (reserve_valid && reserve_id != 0) m_busy[reserve_id] = 1'b1;
      exp_q.push_back(m_wr);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0]            exp_ready;
  logic [W-1:0]            exp_wr;
  int                      c_g;
  logic [N-1:0]            pend;
  register_write_request_t pend_val [N];
  logic                    log_en = 1'b0;
  int                      grant_log[$];

  always @(negedge clk) begin
    exp_ready = '0;
    if (resetn) begin
      c_g = rr_pick(req_valid, m_ptr);
      if (c_g >= 0) exp_ready[c_g] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    exp_wr = (exp_q.size() > 0) ? exp_q.pop_front() : m_wr;
    check("write_request", 64'(write_request), 64'(exp_wr));
    check("busy", 64'(busy), 64'(m_busy));
    if (log_en)
      for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    if (resetn) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i])
          check($sformatf("hold_req%0d", i), {25'd0, req_valid[i], req[i]}, {25'd0, 1'b1, pend_val[i]});
        pend[i]     = req_valid[i] & ~req_ready[i];
        pend_val[i] = req[i];
      end
    end else begin
      pend = '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid     = '0;
    req           = '0;
    reserve_valid = 1'b0;
    reserve_id    = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int exp_order[8];
    exp_order = '{0, 1, 2, 0, 1, 2, 0, 1};
    pend   = '0;
    idle();
    resetn = 1'b0;
    mid();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr", 64'(write_request), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    step();
    resetn = 1'b1;

    // single requester, releasing a busy x5
    reserve_valid = 1'b1; reserve_id = 5;
    step();
    reserve_valid = 1'b0;
    req_valid = 3'b001; req[0] = mk(1, 5, 32'hDEADBEEF);
    mid();
    check("single_ready", 64'(req_ready), 64'h1);
    check("single_busy_set", 64'(busy), 64'h20);
    step();
    idle();
    mid();
    check("single_wr", 64'(write_request), 64'(mk(1, 5, 32'hDEADBEEF)));
    check("single_busy_clr", 64'(busy), 64'h0);

    // fairness burst right after reset
    step(); resetn = 1'b0;
    step(); resetn = 1'b1;
    for (int i = 0; i < N; i++) req[i] = mk(1, 10 + i, 32'hA000_0000 + i);
    req_valid = 3'b111; log_en = 1'b1;
    repeat (6) step();
    req_valid = 3'b011;
    step();
    req_valid = 3'b010;
    step();
    idle(); log_en = 1'b0;
    check("rr_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("rr_order%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));

    // reserve x7, released by requester 1 three cycles later
    reserve_valid = 1'b1; reserve_id = 7;
    step();
    idle();
    mid(); check("x7_busy_c1", 64'(busy[7]), 64'd1);
    step();
    mid(); check("x7_busy_c2", 64'(busy[7]), 64'd1);
    step();
    req_valid = 3'b010; req[1] = mk(1, 7, 32'hC0FFEE07);
    mid();
    check("x7_busy_c3", 64'(busy[7]), 64'd1);
    check("x7_ready", 64'(req_ready), 64'h2);
    step();
    idle();
    mid();
    check("x7_busy_c4", 64'(busy[7]), 64'd0);
    check("x7_wr", 64'(write_request), 64'(mk(1, 7, 32'hC0FFEE07)));

    // same-cycle reserve and release of x9: set wins
    step();
    reserve_valid = 1'b1; reserve_id = 9;
    req_valid = 3'b100; req[2] = mk(1, 9, 32'h0000_0909);
    mid(); check("x9_ready", 64'(req_ready), 64'h4);
    step();
    idle();
    mid();
    check("x9_wr", 64'(write_request), 64'(mk(1, 9, 32'h0000_0909)));
    check("x9_busy", 64'(busy[9]), 64'd1);

    // write to x0 is accepted but suppressed
    step();
    reserve_valid = 1'b1; reserve_id = 0;
    req_valid = 3'b001; req[0] = mk(1, 0, 32'h1234);
    mid(); check("x0_ready", 64'(req_ready), 64'h1);
    step();
    idle();
    mid();
    check("x0_write", 64'(write_request.write), 64'd0);
    check("x0_busy0", 64'(busy[0]), 64'd0);

    // busy=0xF0 (x9 released meanwhile), then reset mid-burst
    step();
    req_valid = 3'b010; req[1] = mk(1, 9, 32'h99);
    for (int r = 4; r < 8; r++) begin
      reserve_valid = 1'b1; reserve_id = rv_reg_id_t'(r);
      step();
      req_valid = '0;
    end
    idle();
    mid(); check("f0_busy", 64'(busy), 64'hF0);
    step();
    for (int i = 0; i < N; i++) req[i] = mk(1, 20 + i, 32'hB000_0000 + i);
    req_valid = 3'b111;
    step();
    step();
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_wr", 64'(write_request), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    step();
    resetn = 1'b1;
    mid(); check("post_rst_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 3'b110;
    mid(); check("post_rst_wr", 64'(write_request), 64'(mk(1, 20, 32'hB000_0000)));
    step();
    req_valid = 3'b100;
    step();
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv32_wb_arbiter.md
RV32_WB_ARBITER -- requirements
Module: rv32_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of write-back requesters (2..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  NUM_REQ  per-requester write-back valid.
REQ-005 SHALL have port req  input  NUM_REQ x register_write_request_t  per-requester {write, id, data}.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
REQ-007 SHALL have port reserve_valid  input  1  issue stage marks a destination register as pending.
REQ-008 SHALL have port reserve_id  input  rv_reg_id_t  register being reserved.
REQ-009 SHALL have port write_request  output  register_write_request_t  registered write port to the register file.
REQ-010 SHALL have port busy  output  32  scoreboard; bit n set = register n has a pending write.

Function
REQ-011 SHALL consider requester i a candidate when req_valid[i]=1.
REQ-012 SHALL grant at most one candidate per cycle by round-robin, starting the search at rr_ptr.
REQ-013 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ after a grant, and leave it unchanged when there is no grant.
REQ-014 SHALL drive req_ready combinationally, with no combinational path from req payload to req_ready.
REQ-015 SHALL define acceptance as req_valid[i] & req_ready[i].
REQ-016 SHALL require each requester to hold req_valid and req stable until accepted; a bench assertion flags violations.
REQ-017 SHALL present an accepted request on write_request at the next rising edge: latency 1, throughput 1 per cycle.
REQ-018 SHALL drive write_request.write=0 in a cycle following no acceptance, with id and data don't-care but held.
REQ-019 SHALL force write_request.write=0 when the accepted request has write=0 or id=0, and SHALL still accept that request.
REQ-020 SHALL, on reserve_valid with reserve_id != 0, set busy[reserve_id] at the next edge.
REQ-021 SHALL clear busy[id] at the edge where write_request is loaded with write=1 for that id.
REQ-022 SHALL give set priority when a reserve and a release target the same id in the same cycle (new in-flight producer), leaving the bit at 1.
REQ-023 SHALL hold busy[0] at 0 permanently.
REQ-024 SHALL leave busy unchanged on a release of a non-busy register (out-of-order safe).
REQ-025 SHALL leave a requester that is never granted waiting with no timeout; with all NUM_REQ valid continuously, each SHALL be granted once every NUM_REQ cycles.

Reset
REQ-026 SHALL, while resetn=0, force rr_ptr=0, busy=0, write_request.write=0, write_request.id=0, write_request.data=0.
REQ-027 SHALL hold req_ready at 0 while resetn=0.
REQ-028 SHALL discard any request in flight when reset asserts mid-operation, with no write issued after release.
REQ-029 SHALL allow grants on the first rising edge after resetn deasserts.

Structure
REQ-030 SHALL take register_write_request_t, rv_reg_id_t and rv32_word from package rv32_types.
REQ-031 SHALL add to rv32_types a constant RV_NUM_REGS=32 and a typedef rv_reg_mask_t (32-bit) for busy.
REQ-032 SHALL place the round-robin grant logic in one sub-module, rv32_rr_arbiter (parameter N; inputs req and ptr; output one-hot grant).
REQ-033 SHALL instantiate rv32_rr_arbiter once and keep the scoreboard inline.

Verification
REQ-034 SHALL cover single requester: req_valid=001, req[0]={1,5,0xDEADBEEF} -> req_ready=001 same cycle; write_request={1,5,0xDEADBEEF} next cycle; busy[5] cleared if set.
REQ-035 SHALL cover all valid for 6 cycles with NUM_REQ=3 after reset -> grant order 0,1,2,0,1,2, one write per cycle.
REQ-036 SHALL cover reserve_id=7 in cycle 0, then requester 1 writes x7 in cycle 3 -> busy[7]=1 for cycles 1..3 and 0 from cycle 4.
REQ-037 SHALL cover same-cycle reserve of x9 and acceptance of a write to x9 -> write issued; busy[9]=1 afterward.
REQ-038 SHALL cover a write to x0 with data 0x1234 and reserve_id=0 -> accepted, write_request.write=0, busy[0]=0.
REQ-039 SHALL cover resetn pulsed low mid-burst with busy=0x0000_00F0 -> busy=0, write=0, rr_ptr=0 immediately; first grant after release goes to requester 0.
